// File: rtl/timer_ctrl.sv
// Countdown timer control stage for an external up/down counter: prescaler,
// one-shot / periodic reload and a sticky interrupt latch with overrun flag.
module timer_ctrl #(
  parameter int Width         = 8,
  parameter int PrescaleWidth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     periodic_i,
  input  logic [Width-1:0]         reload_value_i,
  input  logic [PrescaleWidth-1:0] prescale_i,
  input  logic                     irq_ack_i,
  input  logic [Width-1:0]         count_i,
  output logic                     cnt_enable_o,
  output logic                     cnt_load_o,
  output logic [Width-1:0]         cnt_load_count_o,
  output logic                     cnt_up0_down1_o,
  output logic                     busy_o,
  output logic                     irq_pending_o,
  output logic                     irq_missed_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [PrescaleWidth-1:0] pre_cnt_q, pre_cnt_d;
  logic [PrescaleWidth-1:0] prescale_q, prescale_d;
  logic [Width-1:0]         reload_q, reload_d;
  logic                     periodic_q, periodic_d;
  logic                     irq_pending_q, irq_pending_d;
  logic                     irq_missed_q, irq_missed_d;

  logic tick;
  logic count_zero;
  logic expiry_raw;
  logic expiry;
  logic accept_start;

  // Control outputs depend only on registered state and the counter value,
  // never on start/stop/ack, so the counter sees a clean strobe.
  assign tick         = (state_q == RUN) && (pre_cnt_q == prescale_q);
  assign count_zero   = (count_i == '0);
  assign expiry_raw   = tick && count_zero;
  assign expiry       = expiry_raw && !stop_i;
  assign accept_start = start_i && !stop_i && (state_q != LOAD);

  assign cnt_enable_o     = tick && !count_zero;
  assign cnt_load_o       = (state_q == LOAD) || (expiry_raw && periodic_q);
  assign cnt_load_count_o = reload_q;
  assign cnt_up0_down1_o  = 1'b1;
  assign busy_o           = (state_q == LOAD) || (state_q == RUN);
  assign irq_pending_o    = irq_pending_q;
  assign irq_missed_o     = irq_missed_q;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = '0;
    reload_d   = reload_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;

    if (state_q == RUN) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PrescaleWidth'(1);
    end

    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (expiry_raw && !periodic_q) state_d = DONE;
      DONE:    if (start_i) state_d = LOAD;
      default: state_d = IDLE;
    endcase

    if (accept_start) begin
      state_d    = LOAD;
      reload_d   = reload_value_i;
      prescale_d = prescale_i;
      periodic_d = periodic_i;
    end

    if (stop_i) begin
      state_d   = IDLE;
      pre_cnt_d = '0;
    end
  end

  // A new expiry beats a simultaneous acknowledge; overrun is judged against
  // the flag as it stood before that acknowledge.
  always_comb begin
    irq_pending_d = irq_pending_q;
    irq_missed_d  = irq_missed_q;
    if (irq_ack_i) begin
      irq_pending_d = 1'b0;
      irq_missed_d  = 1'b0;
    end
    if (expiry) begin
      irq_pending_d = 1'b1;
      if (irq_pending_q) irq_missed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pre_cnt_q     <= '0;
      reload_q      <= '0;
      prescale_q    <= '0;
      periodic_q    <= 1'b0;
      irq_pending_q <= 1'b0;
      irq_missed_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      reload_q      <= reload_d;
      prescale_q    <= prescale_d;
      periodic_q    <= periodic_d;
      irq_pending_q <= irq_pending_d;
      irq_missed_q  <= irq_missed_d;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: a behavioural down counter closes the loop; directed
// per-cycle vector table, corner-case sequences and closed-form random runs.
module tb_timer_ctrl;

  logic       clk;
  logic       rst;
  logic       start, stop, periodic, irq_ack;
  logic [7:0] reload_value;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       cnt_enable, cnt_load, cnt_up0_down1, busy, irq_pending, irq_missed;
  logic [7:0] cnt_load_count;

  int checks = 0;
  int errors = 0;

  timer_ctrl #(.Width(8), .PrescaleWidth(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .stop_i           (stop),
    .periodic_i       (periodic),
    .reload_value_i   (reload_value),
    .prescale_i       (prescale),
    .irq_ack_i        (irq_ack),
    .count_i          (count),
    .cnt_enable_o     (cnt_enable),
    .cnt_load_o       (cnt_load),
    .cnt_load_count_o (cnt_load_count),
    .cnt_up0_down1_o  (cnt_up0_down1),
    .busy_o           (busy),
    .irq_pending_o    (irq_pending),
    .irq_missed_o     (irq_missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the driven up/down counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (cnt_load) count <= cnt_load_count;
    else if (cnt_enable) count <= cnt_up0_down1 ? count - 8'd1 : count + 8'd1;
  end

  typedef struct {
    logic       start, stop, ack, per;
    logic [7:0] r;
    logic [3:0] p;
    logic       e_load, e_en, e_busy, e_irq, e_miss;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [33];

  function automatic vec_t mk(input logic st, input logic sp, input logic ak,
                              input logic pe, input logic [7:0] r, input logic [3:0] p,
                              input logic ld, input logic en, input logic bz,
                              input logic iq, input logic ms, input logic [7:0] c);
    vec_t v;
    v.start = st; v.stop = sp; v.ack = ak; v.per = pe; v.r = r; v.p = p;
    v.e_load = ld; v.e_en = en; v.e_busy = bz; v.e_irq = iq; v.e_miss = ms; v.e_cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic set_in(input logic st, input logic sp, input logic ak,
                        input logic pe, input logic [7:0] r, input logic [3:0] p);
    start = st; stop = sp; irq_ack = ak; periodic = pe; reload_value = r; prescale = p;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
  endtask

  function automatic bit is_exp(input int t, input int e1, input int period, input bit per);
    if (per) return (t >= e1) && (((t - e1) % period) == 0);
    return t == e1;
  endfunction

  function automatic bit exp_busy(input int t, input int s, input int e1, input bit per);
    return (t >= 1) && (t <= s) && (per || t <= e1);
  endfunction

  initial begin
    // start, stop, ack, periodic, R, P | load, en, busy, irq, missed, count
    tbl[0]  = mk(1,0,0,0,8'd3,4'd1, 0,0,0,0,0,8'd0);
    tbl[1]  = mk(0,0,0,0,8'd0,4'd0, 1,0,1,0,0,8'd0);
    tbl[2]  = mk(0,0,0,0,8'd0,4'd0, 0,0,1,0,0,8'd3);
    tbl[3]  = mk(0,0,0,0,8'd0,4'd0, 0,1,1,0,0,8'd3);
    tbl[4]  = mk(0,0,0,0,8'd0,4'd0, 0,0,1,0,0,8'd2);
    tbl[5]  = mk(0,0,0,0,8'd0,4'd0, 0,1,1,0,0,8'd2);
    tbl[6]  = mk(0,0,0,0,8'd0,4'd0, 0,0,1,0,0,8'd1);
    tbl[7]  = mk(0,0,0,0,8'd0,4'd0, 0,1,1,0,0,8'd1);
    tbl[8]  = mk(0,0,0,0,8'd0,4'd0, 0,0,1,0,0,8'd0);
    tbl[9]  = mk(0,0,0,0,8'd0,4'd0, 0,0,1,0,0,8'd0);
    tbl[10] = mk(0,0,0,0,8'd0,4'd0, 0,0,0,1,0,8'd0);
    tbl[11] = mk(0,0,1,0,8'd0,4'd0, 0,0,0,1,0,8'd0);
    tbl[12] = mk(0,0,0,0,8'd0,4'd0, 0,0,0,0,0,8'd0);
    tbl[13] = mk(1,0,0,1,8'd2,4'd0, 0,0,0,0,0,8'd0);
    tbl[14] = mk(0,0,0,0,8'd0,4'd0, 1,0,1,0,0,8'd0);
    tbl[15] = mk(0,0,0,0,8'd0,4'd0, 0,1,1,0,0,8'd2);
    tbl[16] = mk(0,0,0,0,8'd0,4'd0, 0,1,1,0,0,8'd1);
    tbl[17] = mk(0,0,0,0,8'd0,4'd0, 1,0,1,0,0,8'd0);
    tbl[18] = mk(0,0,0,0,8'd0,4'd0, 0,1,1,1,0,8'd2);
    tbl[19] = mk(0,0,0,0,8'd0,4'd0, 0,1,1,1,0,8'd1);
    tbl[20] = mk(0,0,0,0,8'd0,4'd0, 1,0,1,1,0,8'd0);
    tbl[21] = mk(0,0,0,0,8'd0,4'd0, 0,1,1,1,1,8'd2);
    tbl[22] = mk(0,0,1,0,8'd0,4'd0, 0,1,1,1,1,8'd1);
    tbl[23] = mk(0,0,0,0,8'd0,4'd0, 1,0,1,0,0,8'd0);
    tbl[24] = mk(0,0,0,0,8'd0,4'd0, 0,1,1,1,0,8'd2);
    tbl[25] = mk(0,0,0,0,8'd0,4'd0, 0,1,1,1,0,8'd1);
    tbl[26] = mk(0,0,1,0,8'd0,4'd0, 1,0,1,1,0,8'd0);
    tbl[27] = mk(0,0,0,0,8'd0,4'd0, 0,1,1,1,1,8'd2);
    tbl[28] = mk(0,1,0,0,8'd0,4'd0, 0,1,1,1,1,8'd1);
    tbl[29] = mk(0,0,0,0,8'd0,4'd0, 0,0,0,1,1,8'd0);
    tbl[30] = mk(1,1,0,0,8'd5,4'd0, 0,0,0,1,1,8'd0);
    tbl[31] = mk(0,0,1,0,8'd0,4'd0, 0,0,0,1,1,8'd0);
    tbl[32] = mk(0,0,0,0,8'd0,4'd0, 0,0,0,0,0,8'd0);

    rst = 1'b1;
    set_in(0, 0, 0, 0, 8'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_load",     32'(cnt_load),       0);
    chk("rst_enable",   32'(cnt_enable),     0);
    chk("rst_busy",     32'(busy),           0);
    chk("rst_irq",      32'(irq_pending),    0);
    chk("rst_missed",   32'(irq_missed),     0);
    chk("rst_loadcnt",  32'(cnt_load_count), 0);
    chk("rst_updown",   32'(cnt_up0_down1),  1);
    adv();

    for (int i = 0; i < 33; i++) begin
      set_in(tbl[i].start, tbl[i].stop, tbl[i].ack, tbl[i].per, tbl[i].r, tbl[i].p);
      @(negedge clk);
      chk($sformatf("vec%0d_load", i),   32'(cnt_load),    32'(tbl[i].e_load));
      chk($sformatf("vec%0d_enable", i), 32'(cnt_enable),  32'(tbl[i].e_en));
      chk($sformatf("vec%0d_busy", i),   32'(busy),        32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_irq", i),    32'(irq_pending), 32'(tbl[i].e_irq));
      chk($sformatf("vec%0d_missed", i), 32'(irq_missed),  32'(tbl[i].e_miss));
      chk($sformatf("vec%0d_count", i),  32'(count),       32'(tbl[i].e_cnt));
      $display("vec %0d: load=%0b en=%0b busy=%0b irq=%0b missed=%0b count=%0d",
               i, cnt_load, cnt_enable, busy, irq_pending, irq_missed, count);
      adv();
    end

    // Restart from RUN with a new reload value, then stop.
    for (int t = 0; t < 10; t++) begin
      if (t == 0) set_in(1, 0, 0, 0, 8'd5, 4'd0);
      if (t == 3) set_in(1, 0, 0, 0, 8'd1, 4'd0);
      if (t == 5) stop = 1'b1;
      @(negedge clk);
      if (t == 2) chk("restart_count5", 32'(count), 5);
      if (t == 4) begin
        chk("restart_load",    32'(cnt_load),       1);
        chk("restart_loadval", 32'(cnt_load_count), 1);
      end
      if (t == 5) chk("restart_count1", 32'(count), 1);
      if (t >= 6) begin
        chk($sformatf("stop_enable_t%0d", t), 32'(cnt_enable), 0);
        chk($sformatf("stop_load_t%0d", t),   32'(cnt_load),   0);
        chk($sformatf("stop_busy_t%0d", t),   32'(busy),       0);
      end
      $display("restart t=%0d: load=%0b en=%0b busy=%0b count=%0d", t, cnt_load, cnt_enable, busy, count);
      adv();
    end

    // Missed interrupt (R=0, P=2, periodic), then asynchronous reset mid-RUN.
    for (int t = 0; t < 14; t++) begin
      if (t == 0)  set_in(1, 0, 0, 1, 8'd0, 4'd2);
      if (t == 8)  irq_ack = 1'b1;
      if (t == 11) set_in(1, 0, 0, 1, 8'd5, 4'd0);
      @(negedge clk);
      $display("missed t=%0d: irq=%0b missed=%0b busy=%0b", t, irq_pending, irq_missed, busy);
      if (t == 4) chk("missed_irq_before", 32'(irq_pending), 0);
      if (t == 5) begin
        chk("missed_irq_first",  32'(irq_pending), 1);
        chk("missed_miss_first", 32'(irq_missed),  0);
      end
      if (t == 8) begin
        chk("missed_irq_second",  32'(irq_pending), 1);
        chk("missed_miss_second", 32'(irq_missed),  1);
      end
      if (t == 9) begin
        chk("ack_irq",  32'(irq_pending), 0);
        chk("ack_miss", 32'(irq_missed),  0);
      end
      if (t == 11) chk("missed_irq_third", 32'(irq_pending), 1);
      if (t == 13) begin
        chk("prerst_enable", 32'(cnt_enable), 1);
        chk("prerst_busy",   32'(busy),       1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",   32'(busy),        0);
        chk("arst_enable", 32'(cnt_enable),  0);
        chk("arst_load",   32'(cnt_load),    0);
        chk("arst_irq",    32'(irq_pending), 0);
        $display("async reset: busy=%0b en=%0b load=%0b irq=%0b", busy, cnt_enable, cnt_load, irq_pending);
      end else begin
        adv();
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_busy",   32'(busy),          0);
    chk("postrst_missed", 32'(irq_missed),    0);
    chk("postrst_updown", 32'(cnt_up0_down1), 1);
    adv();

    // Random scenarios checked against closed-form expiry timing; ack held
    // high so irq_pending is high exactly in the cycle after each expiry.
    for (int n = 0; n < 300; n++) begin
      int r, p, period, e1, s, tend, errs0;
      bit per;
      r      = $urandom_range(0, 7);
      p      = $urandom_range(0, 3);
      per    = 1'($urandom_range(0, 1));
      period = (r + 1) * (p + 1);
      e1     = 1 + period;
      tend   = per ? e1 + 2 * period + 3 : e1 + 3;
      s      = ($urandom_range(0, 2) == 0) ? $urandom_range(1, tend - 1) : 100000;
      errs0  = errors;
      set_in(0, 1, 1, 0, 8'd0, 4'd0);
      adv();
      for (int t = 0; t < tend; t++) begin
        bit e_busy, e_load, e_en, e_irq;
        set_in(t == 0, t == s, 1, per, 8'(r), 4'(p));
        e_busy = exp_busy(t, s, e1, per);
        e_load = (t == 1) || (per && is_exp(t, e1, period, per) && e_busy);
        e_en   = e_busy && (t >= 2) && (((t - 1) % (p + 1)) == 0) && !is_exp(t, e1, period, per);
        e_irq  = (t >= 1) && is_exp(t - 1, e1, period, per) && exp_busy(t - 1, s, e1, per) && (t - 1 != s);
        @(negedge clk);
        chk($sformatf("rnd%0d_t%0d_busy", n, t),   32'(busy),                   32'(e_busy));
        chk($sformatf("rnd%0d_t%0d_load", n, t),   32'(cnt_load),               32'(e_load));
        chk($sformatf("rnd%0d_t%0d_enable", n, t), 32'(cnt_enable),             32'(e_en));
        chk($sformatf("rnd%0d_t%0d_irq", n, t),    32'(irq_pending),            32'(e_irq));
        chk($sformatf("rnd%0d_t%0d_excl", n, t),   32'(cnt_enable & cnt_load),  0);
        chk($sformatf("rnd%0d_t%0d_updown", n, t), 32'(cnt_up0_down1),          1);
        adv();
      end
      $display("rnd %0d: R=%0d P=%0d periodic=%0b stop_at=%0d cycles=%0d new_errors=%0d",
               n, r, p, per, (s == 100000) ? -1 : s, tend, errors - errs0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
